// File: rtl/salamander_clk_en_gen.sv
// Lock-qualified core reset plus three fractional clock enables (CPU, Z80, pixel).
// Optional CLK_EN_PAUSE_EN adds a pause input that freezes the CPU and Z80 enables.
module salamander_clk_en_gen #(
    parameter int unsigned DEN       = 73737373,
    parameter int unsigned NUM_CPU   = 9216000,
    parameter int unsigned NUM_SND   = 3579545,
    parameter int unsigned NUM_PIX   = 6144000,
    parameter int unsigned LOCK_HOLD = 1024,
    parameter int unsigned ACC_W     = 27
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic pll_locked,
`ifdef CLK_EN_PAUSE_EN
    input  logic pause,
`endif
    output logic core_rst,
    output logic ce_cpu,
    output logic ce_snd,
    output logic ce_pix,
    output logic locked_sync
);

    localparam int unsigned HOLD_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);

    localparam logic [ACC_W-1:0] DEN_V     = ACC_W'(DEN);
    localparam logic [ACC_W-1:0] NUM_CPU_V = ACC_W'(NUM_CPU);
    localparam logic [ACC_W-1:0] NUM_SND_V = ACC_W'(NUM_SND);
    localparam logic [ACC_W-1:0] NUM_PIX_V = ACC_W'(NUM_PIX);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              lock_meta;
    logic              run_nxt;
    logic              cpu_hold;
    logic [ACC_W-1:0]  acc_cpu;
    logic [ACC_W-1:0]  acc_snd;
    logic [ACC_W-1:0]  acc_pix;
    logic [ACC_W:0]    cpu_step;
    logic [ACC_W:0]    snd_step;
    logic [ACC_W:0]    pix_step;

`ifdef CLK_EN_PAUSE_EN
    assign cpu_hold = pause;
`else
    assign cpu_hold = 1'b0;
`endif

    // Returns {pulse, next accumulator}; sum cannot overflow since acc, num < DEN.
    function automatic logic [ACC_W:0] acc_step(input logic [ACC_W-1:0] acc,
                                                 input logic [ACC_W-1:0] num);
        logic [ACC_W-1:0] sum;
        sum = acc + num;
        if (sum >= DEN_V) begin
            acc_step = {1'b1, sum - DEN_V};
        end else begin
            acc_step = {1'b0, sum};
        end
    endfunction

    assign cpu_step = acc_step(acc_cpu, NUM_CPU_V);
    assign snd_step = acc_step(acc_snd, NUM_SND_V);
    assign pix_step = acc_step(acc_pix, NUM_PIX_V);

    // True when the FSM will be in RUN after this edge; drives reset release and accumulation.
    assign run_nxt = locked_sync &&
                     ((state == RUN) || ((state == HOLD) && (hold_cnt == HOLD_LAST)));

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            lock_meta   <= 1'b0;
            locked_sync <= 1'b0;
            state       <= WAIT_LOCK;
            hold_cnt    <= '0;
            core_rst    <= 1'b1;
        end else begin
            lock_meta   <= pll_locked;
            locked_sync <= lock_meta;
            core_rst    <= !run_nxt;
            case (state)
                WAIT_LOCK: begin
                    hold_cnt <= '0;
                    if (locked_sync) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!locked_sync) begin
                        state    <= WAIT_LOCK;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state <= RUN;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_sync) begin
                        state    <= WAIT_LOCK;
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    state    <= WAIT_LOCK;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // Accumulators start stepping on the edge that enters RUN, so run cycle k carries k*NUM.
    always_ff @(posedge clk_sys) begin
        if (rst || !run_nxt) begin
            acc_cpu <= '0;
            acc_snd <= '0;
            acc_pix <= '0;
            ce_cpu  <= 1'b0;
            ce_snd  <= 1'b0;
            ce_pix  <= 1'b0;
        end else begin
            {ce_pix, acc_pix} <= pix_step;
            if (cpu_hold) begin
                ce_cpu <= 1'b0;
                ce_snd <= 1'b0;
            end else begin
                {ce_cpu, acc_cpu} <= cpu_step;
                {ce_snd, acc_snd} <= snd_step;
            end
        end
    end

endmodule

// File: tb/tb_salamander_clk_en_gen.sv
// Bench for salamander_clk_en_gen: a small-fraction instance and a default-rate instance
// share stimulus and are checked every cycle against an arithmetic reference model.
module tb_salamander_clk_en_gen;

    localparam int     LH    = 16;
    localparam longint A_DEN = 10;
    localparam longint A_CPU = 3;
    localparam longint A_SND = 7;
    localparam longint A_PIX = 3;
    localparam longint B_DEN = 73737373;
    localparam longint B_CPU = 9216000;
    localparam longint B_SND = 3579545;
    localparam longint B_PIX = 6144000;

    logic clk_sys = 1'b0;
    logic rst = 1'b1;
    logic pll_locked = 1'b0;
    logic pause = 1'b0;

    logic a_core_rst, a_ce_cpu, a_ce_snd, a_ce_pix, a_locked_sync;
    logic b_core_rst, b_ce_cpu, b_ce_snd, b_ce_pix, b_locked_sync;

    int total = 0;
    int bad = 0;

    always #5 clk_sys = ~clk_sys;

    salamander_clk_en_gen #(
        .DEN(10), .NUM_CPU(3), .NUM_SND(7), .NUM_PIX(3), .LOCK_HOLD(LH), .ACC_W(5)
    ) dut_a (
        .clk_sys(clk_sys),
        .rst(rst),
        .pll_locked(pll_locked),
`ifdef CLK_EN_PAUSE_EN
        .pause(pause),
`endif
        .core_rst(a_core_rst),
        .ce_cpu(a_ce_cpu),
        .ce_snd(a_ce_snd),
        .ce_pix(a_ce_pix),
        .locked_sync(a_locked_sync)
    );

    salamander_clk_en_gen #(
        .LOCK_HOLD(LH)
    ) dut_b (
        .clk_sys(clk_sys),
        .rst(rst),
        .pll_locked(pll_locked),
`ifdef CLK_EN_PAUSE_EN
        .pause(pause),
`endif
        .core_rst(b_core_rst),
        .ce_cpu(b_ce_cpu),
        .ce_snd(b_ce_snd),
        .ce_pix(b_ce_pix),
        .locked_sync(b_locked_sync)
    );

    initial begin
        if (A_CPU >= A_DEN || A_SND >= A_DEN || A_PIX >= A_DEN ||
            B_CPU >= B_DEN || B_SND >= B_DEN || B_PIX >= B_DEN) begin
            $fatal(1, "illegal configuration: an enable rate NUM is not below DEN");
        end
    end

    // Reference model: lock history as a streak count, enables as floor(n*NUM/DEN) steps.
    bit m_s1, m_s2;
    int streak, run_k, n_upd;
    bit e_core;
    bit e_ca, e_sa, e_pa, e_cb, e_sb, e_pb;

    function automatic bit step_pulse(longint n, longint num, longint den);
        if (n <= 0) return 1'b0;
        return ((n * num) / den) != (((n - 1) * num) / den);
    endfunction

    task automatic model_step();
        if (rst) begin
            m_s1 = 0; m_s2 = 0; streak = 0; run_k = 0; n_upd = 0; e_core = 1;
            {e_ca, e_sa, e_pa, e_cb, e_sb, e_pb} = '0;
        end else begin
            streak = m_s2 ? streak + 1 : 0;
            m_s2   = m_s1;
            m_s1   = pll_locked;
            e_core = (streak < LH + 1);
            if (e_core) begin
                run_k = 0; n_upd = 0;
                {e_ca, e_sa, e_pa, e_cb, e_sb, e_pb} = '0;
            end else begin
                run_k++;
                e_pa = step_pulse(run_k, A_PIX, A_DEN);
                e_pb = step_pulse(run_k, B_PIX, B_DEN);
                if (pause) begin
                    {e_ca, e_sa, e_cb, e_sb} = '0;
                end else begin
                    n_upd++;
                    e_ca = step_pulse(n_upd, A_CPU, A_DEN);
                    e_sa = step_pulse(n_upd, A_SND, A_DEN);
                    e_cb = step_pulse(n_upd, B_CPU, B_DEN);
                    e_sb = step_pulse(n_upd, B_SND, B_DEN);
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0b required=%0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_sys);
            model_step();
            @(negedge clk_sys);
            chk("a_core_rst", a_core_rst, e_core);
            chk("a_locked_sync", a_locked_sync, m_s2);
            chk("a_ce_cpu", a_ce_cpu, e_ca);
            chk("a_ce_snd", a_ce_snd, e_sa);
            chk("a_ce_pix", a_ce_pix, e_pa);
            chk("b_core_rst", b_core_rst, e_core);
            chk("b_locked_sync", b_locked_sync, m_s2);
            chk("b_ce_cpu", b_ce_cpu, e_cb);
            chk("b_ce_snd", b_ce_snd, e_sb);
            chk("b_ce_pix", b_ce_pix, e_pb);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic edges_until_core(input logic target, input int bound, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (a_core_rst !== target && n < bound);
    endtask

    task automatic edges_until_ls(input logic target, input int bound, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (a_locked_sync !== target && n < bound);
    endtask

    typedef struct {
        logic rst;
        logic lock;
        int   cycles;
        logic exp_core_rst;
        logic exp_ls;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int n;
        int pix_hits[$];
        int first_cpu, first_snd, first_pix;
`ifdef CLK_EN_PAUSE_EN
        int cpu_cnt;
`endif

        vecs[0]  = '{1'b1, 1'b0,  4, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 10, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1,  2, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 16, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1,  1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 50, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0,  2, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0,  1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 30, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1,  1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1,  5, 1'b1, 1'b1};

        for (int i = 0; i < 11; i++) begin
            rst        = vecs[i].rst;
            pll_locked = vecs[i].lock;
            tick(vecs[i].cycles);
            chk($sformatf("vec%0d_core_rst", i), a_core_rst, vecs[i].exp_core_rst);
            chk($sformatf("vec%0d_locked_sync", i), a_locked_sync, vecs[i].exp_ls);
        end

        // Power-up with lock already present.
        rst = 1'b1;
        pll_locked = 1'b1;
        tick(4);
        rst = 1'b0;
        edges_until_core(1'b0, 200, n);
        chk_int("powerup_release_edges", n, 19);
        chk("powerup_b_core_rst", b_core_rst, 1'b0);

        // Fraction pattern and first pulses; currently in run cycle 1.
        first_cpu = 0; first_snd = 0; first_pix = 0;
        for (int k = 1; k <= 100; k++) begin
            if (a_ce_pix) pix_hits.push_back(k);
            if (b_ce_cpu && first_cpu == 0) first_cpu = k;
            if (b_ce_snd && first_snd == 0) first_snd = k;
            if (b_ce_pix && first_pix == 0) first_pix = k;
            tick(1);
        end
        chk_int("pix_count_100", pix_hits.size(), 30);
        if (pix_hits.size() >= 6) begin
            chk_int("pix_hit1", pix_hits[0], 4);
            chk_int("pix_hit2", pix_hits[1], 7);
            chk_int("pix_hit3", pix_hits[2], 10);
            chk_int("pix_hit4", pix_hits[3], 14);
            chk_int("pix_hit5", pix_hits[4], 17);
            chk_int("pix_hit6", pix_hits[5], 20);
        end else begin
            chk_int("pix_hit_list_short", pix_hits.size(), 6);
        end
        chk_int("b_first_cpu", first_cpu, 9);
        chk_int("b_first_snd", first_snd, 21);
        chk_int("b_first_pix", first_pix, 13);

        // Lock loss while running, then re-lock.
        pll_locked = 1'b0;
        edges_until_core(1'b1, 20, n);
        chk_int("lockloss_edges", n, 3);
        chk("lockloss_ce_cpu", a_ce_cpu, 1'b0);
        chk("lockloss_ce_snd", a_ce_snd, 1'b0);
        chk("lockloss_ce_pix", a_ce_pix, 1'b0);
        pll_locked = 1'b1;
        edges_until_core(1'b0, 200, n);
        chk_int("relock_release_edges", n, 19);

        // One-cycle lock glitch at hold count 10.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        edges_until_ls(1'b1, 20, n);
        chk_int("glitch_ls_rise_edges", n, 2);
        tick(11);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        edges_until_ls(1'b0, 10, n);
        chk("glitch_ls_low", a_locked_sync, 1'b0);
        edges_until_ls(1'b1, 10, n);
        chk_int("glitch_ls_back_edges", n, 1);
        edges_until_core(1'b0, 200, n);
        chk_int("glitch_release_edges", n, 17);

`ifdef CLK_EN_PAUSE_EN
        // Pause during run cycles 5..8; currently in run cycle 1.
        pix_hits.delete();
        cpu_cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            pause = (k >= 5 && k <= 8);
            if (a_ce_pix) pix_hits.push_back(k);
            if (a_ce_cpu) cpu_cnt++;
            tick(1);
        end
        pause = 1'b0;
        chk_int("pause_pix_count", pix_hits.size(), 9);
        chk_int("pause_cpu_count", cpu_cnt, 7);
        chk("pause_core_rst", a_core_rst, 1'b0);
`endif

        // Random lock activity and resets, checked cycle by cycle by the model.
        for (int i = 0; i < 60; i++) begin
            pll_locked = ($urandom_range(0, 9) != 0);
            rst        = ($urandom_range(0, 49) == 0);
`ifdef CLK_EN_PAUSE_EN
            pause      = ($urandom_range(0, 3) == 0);
`endif
            tick($urandom_range(1, 25));
        end
        rst = 1'b0;
        pause = 1'b0;
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
